fsm: RTL and testbench
======================

Name:
fsm

Overview:
- Run/idle control FSM for the stopwatch datapath.
- Converts `start`/`stop` commands into a single registered count-enable `en`, which gates the stopwatch time counters.
- One clock domain.
- Optional input synchronizer for asynchronous pushbutton-derived commands.

Parameters:
- SYNC_STAGES, default 0: number of flip-flop synchronizer stages on `start` and `stop`.
  - 0 means inputs are sampled directly.
  - Legal values are 0, 2 and 3. Any other value is a compile-time error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous assert, active-low. Deassertion takes effect on the next rising `clk`.
- start  input  1  level command: begin or resume counting.
- stop  input  1  level command: pause counting.
- en  output  1  count enable to the counters. Registered; 1 while the FSM is in RUN.

Behaviour:
- Reset: already decided, one clock; reset is asynchronous and active-low.
  - While `rst`=0: state=IDLE, `en`=0, all synchronizer flops cleared to 0. Independent of `clk`.
- States: 1-bit Moore machine with IDLE (`en`=0) and RUN (`en`=1). No other reachable state. Any illegal encoding recovers to IDLE on the next edge.
- Effective inputs:
  - s_start and s_stop are `start`/`stop` after SYNC_STAGES flops.
  - With SYNC_STAGES=0 they equal the raw ports.
- Transitions, evaluated at each rising `clk` with `rst`=1:
  - IDLE, s_start=1 and s_stop=0 -> RUN.
  - IDLE, otherwise -> IDLE.
  - RUN, s_stop=1 -> IDLE, regardless of s_start.
  - RUN, otherwise -> RUN.
- Simultaneous start=1 and stop=1: stop has priority.
  - From IDLE the FSM stays IDLE.
  - From RUN it goes to IDLE.
- Level commands are not edge-detected. Holding `start` keeps RUN; holding `stop` keeps IDLE.
- Output: `en` is taken directly from the state register, with no combinational path from inputs.
- Latency with SYNC_STAGES=0: a command present at rising edge k changes `en` immediately after edge k (1-edge latency).
- Latency with SYNC_STAGES=N: N additional clock cycles.
- Pulse width: a command pulse must be high across at least one rising edge to be seen. Shorter pulses may be missed; this is acceptable.
- Reset mid-RUN: `en` drops to 0 asynchronously. After release the FSM is in IDLE and needs a new start.
- No counters, no timeout. `en` holds its value indefinitely with inputs at 0.

Test Plan:
- Reset: `rst`=0 with start/stop=0, then release -> `en`=0 during reset and stays 0 for 3 further cycles.
- Start: start=1 for one cycle (one rising edge) -> `en`=1 after that edge. start back to 0 -> `en` remains 1 for 5+ cycles.
- Stop: from RUN, stop=1 for one edge -> `en`=0 after that edge, and remains 0 after stop returns to 0.
- Simultaneous: start=1 and stop=1 for one edge, once from IDLE and once from RUN -> `en`=0 after the edge in both cases.
- Async reset mid-run: in RUN, assert `rst`=0 between clock edges -> `en`=0 before the next rising edge. After release, `en`=0 until start is applied.
- Synchronizer: SYNC_STAGES=2, start=1 at edge k -> `en` rises after edge k+2. stop=1 at edge m -> `en` falls after edge m+2.

Source files
------------

// File: rtl/fsm.sv
// Run/idle control FSM for the stopwatch datapath.
// Turns level start/stop commands into a registered count enable.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   start : level command, begin or resume counting
//   stop  : level command, pause counting (wins over start)
//   en    : count enable, 1 while in RUN, decoded straight from the state flop
// SYNC_STAGES (0, 2 or 3) adds that many synchronizer flops on start/stop.
module fsm #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic en
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   s_start;
  logic   s_stop;

  // Optional input synchronizer; stage 0 captures the raw port.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_start = start;
    assign s_stop  = stop;
  end else if (SYNC_STAGES == 2 || SYNC_STAGES == 3) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_start_q, sync_start_d;
    logic [SYNC_STAGES-1:0] sync_stop_q,  sync_stop_d;

    always_comb begin
      sync_start_d = {sync_start_q[SYNC_STAGES-2:0], start};
      sync_stop_d  = {sync_stop_q[SYNC_STAGES-2:0],  stop};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_start_q <= '0;
        sync_stop_q  <= '0;
      end else begin
        sync_start_q <= sync_start_d;
        sync_stop_q  <= sync_stop_d;
      end
    end

    assign s_start = sync_start_q[SYNC_STAGES-1];
    assign s_stop  = sync_stop_q[SYNC_STAGES-1];
  end else begin : g_bad_sync
    $error("fsm: SYNC_STAGES must be 0, 2 or 3");
    assign s_start = 1'b0;
    assign s_stop  = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; stop has priority over start in both states.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (s_start && !s_stop) ? RUN : IDLE;
      RUN:     state_d = s_stop ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  assign en = (state_q == RUN);

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for fsm: one instance without synchronizer, one with two
// stages, sharing the same start/stop stimulus.
module tb_fsm;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic stop;
  logic en0;
  logic en2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  fsm #(.SYNC_STAGES(0)) u_fsm0 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .en    (en0)
  );

  fsm #(.SYNC_STAGES(2)) u_fsm2 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .en    (en2)
  );

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got en0=%b en2=%b, expected en0=%b en2=%b",
               name, got[1], got[0], want[1], want[0]);
    end
  endtask

  // Monitor: the enable is a level, so the DUT presents a new value after
  // every edge; compare the queued expectation shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [1:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, {en0, en2}, e);
    end
  end

  // Drive inputs on the falling edge and queue the values expected after
  // the following rising edge (e0: no sync, e2: two-stage sync).
  task automatic step(input logic s, input logic p, input logic e0, input logic e2,
                      input string name);
    @(negedge clk);
    start = s;
    stop  = p;
    exp_q.push_back({e0, e2});
    name_q.push_back(name);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    #12;
    chk("reset_low", {en0, en2}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(0, 0, 0, 0, "after_reset");

    // Single-edge start pulse, then hold with inputs idle.
    step(1, 0, 1, 0, "start_k");
    step(0, 0, 1, 0, "start_k1");
    step(0, 0, 1, 1, "start_k2");
    repeat (5) step(0, 0, 1, 1, "run_hold");

    // Single-edge stop pulse.
    step(0, 1, 0, 1, "stop_m");
    step(0, 0, 0, 1, "stop_m1");
    step(0, 0, 0, 0, "stop_m2");
    step(0, 0, 0, 0, "idle_hold");

    // Simultaneous start+stop from IDLE.
    step(1, 1, 0, 0, "both_idle");
    step(0, 0, 0, 0, "both_idle1");
    step(0, 0, 0, 0, "both_idle2");
    step(0, 0, 0, 0, "both_idle3");

    // Back to RUN, then simultaneous start+stop from RUN.
    step(1, 0, 1, 0, "rerun");
    step(0, 0, 1, 0, "rerun1");
    step(0, 0, 1, 1, "rerun2");
    step(0, 0, 1, 1, "rerun3");
    step(1, 1, 0, 1, "both_run");
    step(0, 0, 0, 1, "both_run1");
    step(0, 0, 0, 0, "both_run2");
    step(0, 0, 0, 0, "both_run3");

    // Held start keeps RUN; stop still wins while start is held.
    step(1, 0, 1, 0, "hold_start0");
    step(1, 0, 1, 0, "hold_start1");
    step(1, 0, 1, 1, "hold_start2");
    step(1, 1, 0, 1, "hold_both");
    step(0, 0, 0, 1, "hold_rel1");
    step(0, 0, 0, 0, "hold_rel2");
    step(0, 0, 0, 0, "hold_rel3");

    // Enter RUN, then reset asynchronously between edges.
    step(1, 0, 1, 0, "pre_rst0");
    step(0, 0, 1, 0, "pre_rst1");
    step(0, 0, 1, 1, "pre_rst2");
    drain();
    rst = 1'b0;
    #1;
    chk("async_reset", {en0, en2}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(0, 0, 0, 0, "post_rst_idle");
    step(1, 0, 1, 0, "post_rst_start");
    step(0, 0, 1, 0, "post_rst_start1");
    step(0, 0, 1, 1, "post_rst_start2");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
